inst_prefetch_queue: RTL
========================

// Module: inst_prefetch_queue
// PURPOSE
//   Fetch front end that sits upstream of the decode/execute control unit.
//   Generates sequential fetch addresses, issues one request at a time to the
//   instruction memory, and buffers returned words with their PC in a FIFO.
//   The FIFO feeds decode through a valid/ready handshake. A taken-branch or
//   jump redirect flushes the queue and squashes any in-flight response.
// PARAMETERS
//   ADDRESS_WIDTH     5   PC/address is ADDRESS_WIDTH+1 bits (64-word imem)
//   INSTRUCTION_SIZE  32  instruction word width
//   DEPTH             4   queue entries; power of 2, >= 2
// PORTS
//   clk             in   1                  clock, rising edge
//   rst             in   1                  asynchronous reset, active-low
//   redirect_valid  in   1                  load new PC and flush this cycle
//   redirect_pc     in   ADDRESS_WIDTH+1    redirect target
//   imem_req        out  1                  fetch request, one-cycle pulse
//   imem_addr       out  ADDRESS_WIDTH+1    fetch address, valid with imem_req
//   imem_rvalid     in   1                  response valid, >=1 cycle after req
//   imem_rdata      in   INSTRUCTION_SIZE   response word
//   inst_valid      out  1                  head entry valid to decode
//   inst_ready      in   1                  decode accepts head entry
//   inst_data       out  INSTRUCTION_SIZE   head instruction
//   inst_pc         out  ADDRESS_WIDTH+1    PC of head instruction
//   occupancy       out  $clog2(DEPTH)+1    entries currently held
// BEHAVIOUR
// - Reset (rst low, async): fetch_pc=0, queue empty, FSM=IDLE, squash=0;
//   inst_valid=0, imem_req=0, occupancy=0, inst_data/inst_pc=0.
// - FSM: IDLE (no request outstanding), WAIT (one outstanding),
//   WAIT_SQUASH (one outstanding, its response is discarded).
// - imem_req = (FSM==IDLE) && (occupancy < DEPTH) && !redirect_valid;
//   imem_addr = fetch_pc. Issuing: record req_pc=fetch_pc,
//   fetch_pc <= fetch_pc+1 (wraps 2^(ADDRESS_WIDTH+1)-1 -> 0), IDLE->WAIT.
// - A slot is reserved at issue: a response can never overflow the queue.
// - WAIT + imem_rvalid: push {req_pc, imem_rdata}, ->IDLE. A new request may
//   issue in the cycle after return, not the same cycle.
// - WAIT_SQUASH + imem_rvalid: drop the word, ->IDLE.
// - imem_rvalid in IDLE is ignored.
// - Pop when inst_valid && inst_ready; inst_valid = (occupancy != 0).
//   Head outputs come from registered storage; no combinational path from
//   imem_rdata to inst_*.
// - Push and pop in the same cycle: occupancy unchanged, order preserved.
// - Min latency: imem_req at cycle N, rvalid at N+1, inst_valid at N+2.
// - redirect_valid has top priority. Same edge: queue cleared (occupancy=0),
//   fetch_pc <= redirect_pc, no request issued, any pop ignored.
//   WAIT or WAIT_SQUASH -> WAIT_SQUASH; IDLE stays IDLE.
//   A response arriving in the redirect cycle is discarded and the FSM goes
//   to IDLE. A first request to redirect_pc issues the next cycle.
// - Back-to-back redirects: the last redirect_pc wins.
// - inst_ready while empty: no effect. Holding inst_ready low: head stable.
// - Reset mid-transaction: all state cleared; a late rvalid lands in IDLE and
//   is ignored.
// TESTING
// - Reset release, imem with 1-cycle latency returning word=0x1000_0000+addr,
//   inst_ready=1 -> inst_pc 0,1,2,... with matching data; first inst_valid
//   2 cycles after first imem_req.
// - inst_ready=0 for 20 cycles -> occupancy saturates at 4, imem_req stops.
//   Ready=1 -> words 0..3 in order, fetch resumes at addr 4.
// - Redirect to 0x20 while WAIT with 3-cycle imem latency -> stale response
//   dropped, queue empty next cycle, next imem_addr=0x20, inst_pc=0x20 first.
// - Redirect coinciding with imem_rvalid and a pop -> nothing pushed,
//   occupancy=0, imem_addr=redirect_pc the cycle after.
// - Sequential fetch past 63 -> inst_pc 62,63,0,1.
// - rst low mid-WAIT, rvalid asserted after release -> ignored,
//   first inst_pc=0.

Source files
------------

// File: rtl/inst_prefetch_queue.sv
// Instruction prefetch front end: sequential fetch with at most one outstanding
// imem request, feeding a PC-tagged FIFO toward decode; redirects flush and squash.
//
// state          | meaning
// ST_IDLE        | no request outstanding, a new fetch may issue
// ST_WAIT        | one request outstanding, its response will be queued
// ST_WAIT_SQUASH | one request outstanding, its response will be dropped
module inst_prefetch_queue #(
    parameter int ADDRESS_WIDTH    = 5,
    parameter int INSTRUCTION_SIZE = 32,
    parameter int DEPTH            = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          redirect_valid,
    input  logic [ADDRESS_WIDTH:0]        redirect_pc,
    output logic                          imem_req,
    output logic [ADDRESS_WIDTH:0]        imem_addr,
    input  logic                          imem_rvalid,
    input  logic [INSTRUCTION_SIZE-1:0]   imem_rdata,
    output logic                          inst_valid,
    input  logic                          inst_ready,
    output logic [INSTRUCTION_SIZE-1:0]   inst_data,
    output logic [ADDRESS_WIDTH:0]        inst_pc,
    output logic [$clog2(DEPTH):0]        occupancy
);

    localparam int PW = ADDRESS_WIDTH + 1;
    localparam int IW = $clog2(DEPTH);
    localparam int CW = IW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_WAIT        = 2'd1,
        ST_WAIT_SQUASH = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [PW-1:0]               fetch_pc;
    logic [PW-1:0]               req_pc;
    logic [INSTRUCTION_SIZE-1:0] q_data [DEPTH];
    logic [PW-1:0]               q_pc   [DEPTH];
    logic [IW-1:0]               wr_ptr;
    logic [IW-1:0]               rd_ptr;
    logic [CW-1:0]               count;
    logic                        issue;
    logic                        push;
    logic                        pop;

    // Issue only reserves a slot implicitly: with a single outstanding request
    // and count < DEPTH at issue, the returning word always fits.
    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        push      = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (!redirect_valid && (count < DEPTH_C)) begin
                    issue     = 1'b1;
                    state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (imem_rvalid) begin
                    push      = !redirect_valid;
                    state_nxt = ST_IDLE;
                end else if (redirect_valid) begin
                    state_nxt = ST_WAIT_SQUASH;
                end
            end
            ST_WAIT_SQUASH: begin
                if (imem_rvalid) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign pop = inst_valid && inst_ready && !redirect_valid;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            fetch_pc <= '0;
            req_pc   <= '0;
        end else begin
            state <= state_nxt;
            if (redirect_valid) begin
                fetch_pc <= redirect_pc;
            end else if (issue) begin
                fetch_pc <= fetch_pc + 1'b1;
            end
            if (issue) begin
                req_pc <= fetch_pc;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                q_data[i] <= '0;
                q_pc[i]   <= '0;
            end
        end else if (redirect_valid) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                q_data[wr_ptr] <= imem_rdata;
                q_pc[wr_ptr]   <= req_pc;
                wr_ptr         <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    // Request is held off while reset is asserted so nothing leaks out of a
    // block that is still being cleared.
    assign imem_req   = rst && (state == ST_IDLE) && (count < DEPTH_C) && !redirect_valid;
    assign imem_addr  = fetch_pc;
    assign inst_valid = (count != '0);
    assign inst_data  = q_data[rd_ptr];
    assign inst_pc    = q_pc[rd_ptr];
    assign occupancy  = count;

endmodule
